pll_lock_sequencer: RTL
=======================

// Module: pll_lock_sequencer
// PURPOSE
//  Reset/lock sequencer that drives the fabric PLL reset and qualifies its locked output.
//  Runs on the 50 MHz reference clock, sits between board reset and the PLL/RNG fabric.
//  Pulses PLL reset and waits for a stable lock. Retries on timeout and re-sequences on lock loss.
//  Releases downstream synchronous-logic reset only while lock is qualified.
// PARAMETERS
//  RST_PULSE_CYCLES    16     refclk cycles pll_rst is held high per attempt (>=1)
//  LOCK_TIMEOUT_CYCLES 50000  cycles in WAIT_LOCK before an attempt is declared failed
//  STABLE_CYCLES       1024   consecutive locked cycles required before READY (>=1)
//  MAX_RETRIES         4      failed attempts before FAIL (>=1)
//  CNT_W               16     shared cycle-counter width; all cycle params must be < 2**CNT_W
//  RETRY_W             3      retry_cnt width; MAX_RETRIES must be < 2**RETRY_W
// PORTS
//  refclk        in   1        reference clock, all logic on rising edge
//  rst_n         in   1        asynchronous active-low reset, async assert, sync-released upstream
//  pll_locked    in   1        PLL locked, asynchronous to refclk, 2-FF synchronised -> locked_s
//  retry_req     in   1        1-cycle pulse, forces a fresh acquisition
//  pll_rst       out  1        active-high reset to PLL
//  sys_rst_n     out  1        active-low reset to downstream logic, 1 only in READY
//  ready         out  1        lock qualified
//  fail          out  1        acquisition abandoned after MAX_RETRIES
//  retry_cnt     out  RETRY_W  failed attempts in current acquisition
//  lock_loss_cnt out  8        lock losses seen in READY, saturates at 255
// BEHAVIOUR
//  Reset (rst_n=0, async): state=RESET_PLL, cnt=0, pll_rst=1, sys_rst_n=0, ready=0, fail=0,
//    retry_cnt=0, lock_loss_cnt=0, sync FFs=0. All outputs registered.
//  RESET_PLL: pll_rst=1. cnt counts 0..RST_PULSE_CYCLES-1, then -> WAIT_LOCK, cnt=0.
//  WAIT_LOCK: pll_rst=0.
//    locked_s=1 -> STABILIZE, cnt=0.
//    cnt==LOCK_TIMEOUT_CYCLES-1 with no lock -> retry_cnt+1. If the new value ==MAX_RETRIES -> FAIL,
//      otherwise -> RESET_PLL, cnt=0.
//  STABILIZE: counts consecutive locked_s=1 cycles.
//    Count reaches STABLE_CYCLES -> READY.
//    locked_s=0 -> WAIT_LOCK with cnt=0 (timeout restarts). A glitch is not a retry.
//  READY: ready=1 and sys_rst_n=1 from the first cycle in READY.
//    locked_s=0 -> lock_loss_cnt+1 (saturating), retry_cnt=0, -> RESET_PLL.
//    ready and sys_rst_n drop on the next edge.
//  FAIL: fail=1, pll_rst=1, sys_rst_n=0. Held until retry_req or rst_n.
//  retry_req: in any state except RESET_PLL -> RESET_PLL with cnt=0, retry_cnt=0, fail=0.
//    Ignored in RESET_PLL (pulse not restarted).
//    Same cycle as lock loss in READY: retry_req path taken, lock_loss_cnt still increments.
//  Latency: pll_locked rise -> locked_s after 2 edges -> ready STABLE_CYCLES+1 edges later
//    (+1 for async sampling).
//  pll_rst=1 exactly in RESET_PLL, FAIL and reset. sys_rst_n=1 exactly in READY.
//  No output glitches: every output comes from a flop.
// TESTING (RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, STABLE_CYCLES=8, MAX_RETRIES=3)
//  Release rst_n with pll_locked=0 -> pll_rst=1 for 4 cycles, then 0; no ready.
//  Raise pll_locked 6 cycles after pll_rst falls, hold -> ready=1 and sys_rst_n=1 within 11+-1 cycles;
//    retry_cnt=0.
//  pll_locked never rises -> three 4-high/20-low pll_rst cycles, retry_cnt 1,2,3.
//    Then fail=1 and pll_rst=1 held. retry_req -> fail=0, retry_cnt=0, new 4-cycle pulse.
//  In STABILIZE, drop pll_locked for 3 cycles after 5 locked cycles -> back to WAIT_LOCK,
//    retry_cnt unchanged; ready only after 8 fresh consecutive locked cycles.
//  In READY, drop pll_locked -> ready/sys_rst_n fall within 3 cycles, lock_loss_cnt=1,
//    pll_rst pulses 4 cycles. Repeat 300x -> lock_loss_cnt saturates at 255.
//  Assert rst_n=0 mid-STABILIZE and mid-READY -> all outputs at reset values immediately (async),
//    sequence restarts cleanly on release.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
// Drives the fabric PLL reset, waits for a stable lock and only then releases
// downstream reset. Failed attempts (lock timeout) are retried up to MAX_RETRIES,
// after which the sequencer parks in FAIL until retry_req or board reset.
// A lock loss while READY re-runs the whole acquisition.
module pll_lock_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int STABLE_CYCLES       = 1024,
    parameter int MAX_RETRIES         = 4,
    parameter int CNT_W               = 16,
    parameter int RETRY_W             = 3
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               pll_locked,
    input  logic               retry_req,
    output logic               pll_rst,
    output logic               sys_rst_n,
    output logic               ready,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [7:0]         lock_loss_cnt
);

    typedef enum logic [2:0] {
        ST_RESET_PLL,
        ST_WAIT_LOCK,
        ST_STABILIZE,
        ST_READY,
        ST_FAIL
    } state_t;

    // Terminal counts, pre-sized to the shared counter width.
    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [RETRY_W-1:0] retry_reg, retry_next;
    logic [RETRY_W-1:0] retry_inc;
    logic [7:0]         loss_reg, loss_next;
    logic               sync1_reg, sync2_reg;
    logic               locked_s;

    assign locked_s      = sync2_reg;
    assign retry_inc     = retry_reg + RETRY_W'(1);
    assign retry_cnt     = retry_reg;
    assign lock_loss_cnt = loss_reg;

    // Two-flop synchroniser for the asynchronous PLL lock indication.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= pll_locked;
            sync2_reg <= sync1_reg;
        end
    end

    // State, shared cycle counter, retry and lock-loss counters.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RESET_PLL;
            cnt_reg   <= '0;
            retry_reg <= '0;
            loss_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            retry_reg <= retry_next;
            loss_reg  <= loss_next;
        end
    end

    // Next-state logic; retry_req overrides everything except an ongoing PLL pulse.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        retry_next = retry_reg;
        loss_next  = loss_reg;
        case (state_reg)
            ST_RESET_PLL: begin
                if (cnt_reg == RST_LAST) begin
                    state_next = ST_WAIT_LOCK;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_next = ST_STABILIZE;
                    cnt_next   = '0;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    retry_next = retry_inc;
                    cnt_next   = '0;
                    state_next = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_RESET_PLL;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_STABILIZE: begin
                // A dropout restarts the wait (and its timeout) without costing a retry.
                if (!locked_s) begin
                    state_next = ST_WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt_reg == STABLE_LAST) begin
                    state_next = ST_READY;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_READY: begin
                if (!locked_s) begin
                    if (loss_reg != 8'hFF) begin
                        loss_next = loss_reg + 8'd1;
                    end
                    retry_next = '0;
                    state_next = ST_RESET_PLL;
                    cnt_next   = '0;
                end
            end
            ST_FAIL: begin
                state_next = ST_FAIL;
            end
            default: begin
                state_next = ST_RESET_PLL;
                cnt_next   = '0;
            end
        endcase
        if (retry_req && (state_reg != ST_RESET_PLL)) begin
            state_next = ST_RESET_PLL;
            cnt_next   = '0;
            retry_next = '0;
        end
    end

    // Registered outputs decoded from the next state so they change with the state.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            pll_rst   <= (state_next == ST_RESET_PLL) || (state_next == ST_FAIL);
            sys_rst_n <= (state_next == ST_READY);
            ready     <= (state_next == ST_READY);
            fail      <= (state_next == ST_FAIL);
        end
    end

endmodule
